// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared encodings for the pipeline hazard/control unit.
//   - fwd_sel_e   : operand source select presented to the ID/EXE operand muxes
//   - mdu_state_e : state of the multi-cycle multiply/divide hold FSM
//   - MDU_CNT_W   : width of the MDU hold down-counter
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      FWD_RF     = 2'd0,   // register file value
      FWD_EXE    = 2'd1,   // ALU result currently in EXE
      FWD_MEM    = 2'd2,   // ALU result currently in MEM
      FWD_MEM_LD = 2'd3    // load data returning in MEM
   } fwd_sel_e;

   typedef enum logic {
      MDU_IDLE = 1'b0,
      MDU_RUN  = 1'b1
   } mdu_state_e;

   localparam int MDU_CNT_W = 4;

endpackage

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
//   RAW hazard check for a single ID source operand against the EXE and MEM
//   destinations.
//   Ports:
//     src_used, src_addr             : operand valid / register address in ID
//     id_is_store                    : ID instruction is a store
//     exe_wen, exe_is_load, exe_waddr: EXE destination info
//     mem_wen, mem_is_load, mem_waddr: MEM destination info
//     fwd_sel                        : operand source select (fwd_sel_e codes)
//     load_use                       : operand needs a value still being loaded in EXE
//     store_fwd                      : store data will be picked up in MEM from WB
//   STORE_SRC marks the operand that carries store data (src1).
module hazard_fwd_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW    = 5,
   parameter bit STORE_SRC = 1'b0
) (
   input  logic              src_used,
   input  logic [REG_AW-1:0] src_addr,
   input  logic              id_is_store,
   input  logic              exe_wen,
   input  logic              exe_is_load,
   input  logic [REG_AW-1:0] exe_waddr,
   input  logic              mem_wen,
   input  logic              mem_is_load,
   input  logic [REG_AW-1:0] mem_waddr,
   output logic [1:0]        fwd_sel,
   output logic              load_use,
   output logic              store_fwd
);

   logic active;
   logic exe_hit;
   logic mem_hit;

   // r0 is hard-wired zero and never participates in forwarding.
   assign active  = src_used && (src_addr != '0);
   assign exe_hit = active && exe_wen && (exe_waddr == src_addr);
   assign mem_hit = active && mem_wen && (mem_waddr == src_addr);

   always_comb begin
      fwd_sel   = FWD_RF;
      load_use  = 1'b0;
      store_fwd = 1'b0;
      // The youngest producer (EXE) wins over MEM.
      if (exe_hit) begin
         if (!exe_is_load) begin
            fwd_sel = FWD_EXE;
         end else if (STORE_SRC && id_is_store) begin
            // Store data is not needed until MEM, where the load result sits in WB.
            store_fwd = 1'b1;
         end else begin
            load_use = 1'b1;
         end
      end else if (mem_hit) begin
         fwd_sel = mem_is_load ? FWD_MEM_LD : FWD_MEM;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard/control unit for the 5-stage pipeline (IF/ID/EXE/MEM/WB).
//   Ports:
//     clk, rst                 : clock, synchronous active-high reset
//     debug_en, debug_step     : debug hold; rising edge of step releases one cycle
//     id_src_used/id_src_addr  : NUM_SRC operand valids / packed addresses in ID
//     id_is_branch/store/mdu   : ID instruction class
//     exe_*, mem_*             : destination info of the EXE and MEM instructions
//     mem_req, mem_ready       : variable-latency memory handshake
//     fwd_sel, store_fwd       : forwarding selects (2 bits per source)
//     *_en, *_rst              : stage register enables and bubble clears
//     mdu_busy                 : MDU hold FSM is running and still holding ID
//     stall_cycles             : saturating count of cycles with id_en low
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int NUM_SRC      = 2,
   parameter int REG_AW       = 5,
   parameter int FLUSH_CYCLES = 3,
   parameter int MDU_LATENCY  = 4,
   parameter int CNT_W        = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      debug_en,
   input  logic                      debug_step,
   input  logic [NUM_SRC-1:0]        id_src_used,
   input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
   input  logic                      id_is_branch,
   input  logic                      id_is_store,
   input  logic                      id_is_mdu,
   input  logic                      exe_wen,
   input  logic                      exe_is_load,
   input  logic [REG_AW-1:0]         exe_waddr,
   input  logic                      mem_wen,
   input  logic                      mem_is_load,
   input  logic [REG_AW-1:0]         mem_waddr,
   input  logic                      mem_req,
   input  logic                      mem_ready,
   output logic [NUM_SRC*2-1:0]      fwd_sel,
   output logic                      store_fwd,
   output logic                      if_en,
   output logic                      id_en,
   output logic                      exe_en,
   output logic                      mem_en,
   output logic                      wb_en,
   output logic                      if_rst,
   output logic                      id_rst,
   output logic                      exe_rst,
   output logic                      mem_rst,
   output logic                      wb_rst,
   output logic                      mdu_busy,
   output logic [CNT_W-1:0]          stall_cycles
);

   // ---------------- forwarding / load-use per source ----------------
   logic [NUM_SRC-1:0] lu_vec;
   logic [NUM_SRC-1:0] sf_vec;

   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [1:0] sel_w;
      hazard_fwd_unit #(
         .REG_AW   (REG_AW),
         .STORE_SRC(gi == 1)
      ) u_fwd (
         .src_used   (id_src_used[gi]),
         .src_addr   (id_src_addr[gi*REG_AW +: REG_AW]),
         .id_is_store(id_is_store),
         .exe_wen    (exe_wen),
         .exe_is_load(exe_is_load),
         .exe_waddr  (exe_waddr),
         .mem_wen    (mem_wen),
         .mem_is_load(mem_is_load),
         .mem_waddr  (mem_waddr),
         .fwd_sel    (sel_w),
         .load_use   (lu_vec[gi]),
         .store_fwd  (sf_vec[gi])
      );
      assign fwd_sel[gi*2 +: 2] = rst ? FWD_RF : sel_w;
   end

   assign store_fwd = !rst && (|sf_vec);

   // ---------------- state ----------------
   logic                 step_prev_q, step_prev_d;
   logic [2:0]           flush_cnt_q, flush_cnt_d;
   mdu_state_e           mdu_state_q, mdu_state_d;
   logic [MDU_CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;
   logic [CNT_W-1:0]     stall_q, stall_d;

   logic load_use;
   logic dbg_hold;
   logic mem_wait;
   logic frozen;
   logic mdu_stall;
   logic id_stall;

   assign load_use = |lu_vec;
   // Only the first cycle of a step request releases the pipeline.
   assign dbg_hold = debug_en && !(debug_step && !step_prev_q);
   assign mem_wait = mem_req && !mem_ready;
   assign frozen   = dbg_hold || mem_wait;

   // A load-use stall blocks MDU entry, so the MDU op is not counted twice.
   assign mdu_stall = (mdu_state_q == MDU_RUN)  ? (mdu_cnt_q != '0)
                                                : (id_is_mdu && !load_use);
   assign id_stall  = load_use || mdu_stall;
   // The release cycle of RUN no longer holds ID, so it is not reported busy.
   assign mdu_busy  = (mdu_state_q == MDU_RUN) && (mdu_cnt_q != '0);
   assign stall_cycles = stall_q;

   // ---------------- stage enables / clears ----------------
   always_comb begin
      if_en   = 1'b1;
      id_en   = 1'b1;
      exe_en  = 1'b1;
      mem_en  = 1'b1;
      wb_en   = 1'b1;
      if_rst  = 1'b0;
      id_rst  = 1'b0;
      exe_rst = 1'b0;
      mem_rst = 1'b0;
      wb_rst  = 1'b0;
      if (rst) begin
         if_rst  = 1'b1;
         id_rst  = 1'b1;
         exe_rst = 1'b1;
         mem_rst = 1'b1;
         wb_rst  = 1'b1;
      end else if (dbg_hold) begin
         if_en  = 1'b0;
         id_en  = 1'b0;
         exe_en = 1'b0;
         mem_en = 1'b0;
         wb_en  = 1'b0;
      end else if (mem_wait) begin
         if_en  = 1'b0;
         id_en  = 1'b0;
         exe_en = 1'b0;
         mem_en = 1'b0;
         wb_rst = 1'b1;
      end else if (id_stall) begin
         if_en   = 1'b0;
         id_en   = 1'b0;
         exe_rst = 1'b1;
      end else if (id_is_branch || (flush_cnt_q != '0)) begin
         id_rst = 1'b1;
      end
   end

   // ---------------- next state ----------------
   always_comb begin
      step_prev_d = debug_step;
      flush_cnt_d = flush_cnt_q;
      mdu_state_d = mdu_state_q;
      mdu_cnt_d   = mdu_cnt_q;
      stall_d     = stall_q;

      if (!frozen) begin
         // The cycle the branch leaves ID is the first bubble.
         if (id_is_branch && !id_stall) begin
            flush_cnt_d = 3'(FLUSH_CYCLES - 1);
         end else if (flush_cnt_q != '0) begin
            flush_cnt_d = flush_cnt_q - 3'd1;
         end

         case (mdu_state_q)
            MDU_IDLE: begin
               if (id_is_mdu && !load_use) begin
                  mdu_state_d = MDU_RUN;
                  mdu_cnt_d   = MDU_CNT_W'(MDU_LATENCY - 1);
               end
            end
            MDU_RUN: begin
               if (mdu_cnt_q != '0) begin
                  mdu_cnt_d = mdu_cnt_q - 1'b1;
               end else begin
                  mdu_state_d = MDU_IDLE;
               end
            end
            default: mdu_state_d = MDU_IDLE;
         endcase
      end

      if (!id_en && (stall_q != '1)) begin
         stall_d = stall_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         step_prev_q <= 1'b0;
         flush_cnt_q <= '0;
         mdu_state_q <= MDU_IDLE;
         mdu_cnt_q   <= '0;
         stall_q     <= '0;
      end else begin
         step_prev_q <= step_prev_d;
         flush_cnt_q <= flush_cnt_d;
         mdu_state_q <= mdu_state_d;
         mdu_cnt_q   <= mdu_cnt_d;
         stall_q     <= stall_d;
      end
   end

endmodule
